// File: rtl/perceptron_trainer_fixed.sv
// perceptron_trainer_fixed
// Sequential trainer for one fixed-point perceptron neuron over a 4-pattern
// truth table. It runs perceptron learning epochs until one epoch has no
// errors or the epoch limit is reached, then holds the learned weights.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   start               begin training (only honoured in IDLE/DONE)
//   in1, in2            packed pattern inputs x1[p]/x2[p], word p at [p*tam +: tam]
//   d                   desired output per pattern
//   w0_init..w2_init    initial weights (bias, x1, x2)
//   w0, w1, w2          current / learned weights
//   busy, done          training in progress / finished (held)
//   converged           last epoch had zero errors (valid with done)
//   epochs              number of epochs executed
module perceptron_trainer_fixed #(
    parameter int unsigned tam        = 16,
    parameter int unsigned FRAC       = 8,
    parameter int unsigned ETA_SHIFT  = 2,
    parameter int unsigned MAX_EPOCHS = 64
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [4*tam-1:0]                      in1,
    input  logic [4*tam-1:0]                      in2,
    input  logic [3:0]                            d,
    input  logic [tam-1:0]                        w0_init,
    input  logic [tam-1:0]                        w1_init,
    input  logic [tam-1:0]                        w2_init,
    output logic [tam-1:0]                        w0,
    output logic [tam-1:0]                        w1,
    output logic [tam-1:0]                        w2,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  converged,
    output logic [$clog2(MAX_EPOCHS+1)-1:0]       epochs
);

    localparam int unsigned EW  = $clog2(MAX_EPOCHS + 1);
    localparam int unsigned PW  = 2 * tam;

    localparam logic signed [tam-1:0] MAXV = {1'b0, {(tam-1){1'b1}}};
    localparam logic signed [tam-1:0] MINV = {1'b1, {(tam-1){1'b0}}};
    localparam logic signed [PW-1:0]  MAXE = {{tam{1'b0}}, MAXV};
    localparam logic signed [PW-1:0]  MINE = {{tam{1'b1}}, MINV};
    localparam logic signed [tam-1:0] ONE  = tam'(1) << FRAC;
    localparam logic signed [tam-1:0] ETA  = ONE >>> ETA_SHIFT;
    localparam logic signed [tam-1:0] NETA = -ETA;
    localparam logic [EW-1:0]         LAST_EPOCH = EW'(MAX_EPOCHS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EVAL,
        S_UPDATE,
        S_CHECK,
        S_DONE
    } state_t;

    // Saturating tam-bit signed add.
    function automatic logic signed [tam-1:0] sat_add(
        input logic signed [tam-1:0] a,
        input logic signed [tam-1:0] b
    );
        logic [tam:0] s;
        s = {a[tam-1], a} + {b[tam-1], b};
        if (s[tam] != s[tam-1]) begin
            return s[tam] ? MINV : MAXV;
        end
        return s[tam-1:0];
    endfunction

    // Full-width signed product, arithmetic shift by FRAC, clamp to tam bits.
    function automatic logic signed [tam-1:0] sat_scale(
        input logic signed [tam-1:0] w,
        input logic signed [tam-1:0] x
    );
        logic signed [PW-1:0] we;
        logic signed [PW-1:0] xe;
        logic signed [PW-1:0] prod;
        logic signed [PW-1:0] sh;
        we   = {{tam{w[tam-1]}}, w};
        xe   = {{tam{x[tam-1]}}, x};
        prod = we * xe;
        sh   = prod >>> FRAC;
        if (sh > MAXE) begin
            return MAXV;
        end
        if (sh < MINE) begin
            return MINV;
        end
        return sh[tam-1:0];
    endfunction

    state_t                 state_q;
    logic signed [tam-1:0]  x1_q [4];
    logic signed [tam-1:0]  x2_q [4];
    logic [3:0]             d_q;
    logic signed [tam-1:0]  w0_q, w1_q, w2_q;
    logic                   err_pos_q, err_neg_q;
    logic [2:0]             errcnt_q;
    logic [1:0]             p_q;
    logic [EW-1:0]          epochs_q;
    logic                   busy_q, done_q, conv_q;

    // Datapath for the current pattern.
    logic signed [tam-1:0]  x1_cur, x2_cur;
    logic signed [tam-1:0]  t1_d, t2_d, sum_d;
    logic                   y_d;
    logic                   err_pos_d, err_neg_d;
    logic signed [tam-1:0]  delta_d;
    logic signed [tam-1:0]  w0_d, w1_d, w2_d;

    always_comb begin
        x1_cur    = x1_q[p_q];
        x2_cur    = x2_q[p_q];
        t1_d      = sat_scale(w1_q, x1_cur);
        t2_d      = sat_scale(w2_q, x2_cur);
        sum_d     = sat_add(sat_add(w0_q, t1_d), t2_d);
        // strictly positive activation: sum == 0 gives y = 0
        y_d       = !sum_d[tam-1] && (sum_d != '0);
        err_pos_d = d_q[p_q] && !y_d;
        err_neg_d = !d_q[p_q] && y_d;
        delta_d   = err_pos_q ? ETA : NETA;
        w0_d      = w0_q;
        w1_d      = w1_q;
        w2_d      = w2_q;
        if (err_pos_q || err_neg_q) begin
            w0_d = sat_add(w0_q, delta_d);
            if (x1_cur != '0) begin
                w1_d = sat_add(w1_q, delta_d);
            end
            if (x2_cur != '0) begin
                w2_d = sat_add(w2_q, delta_d);
            end
        end
    end

    // Training FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            for (int i = 0; i < 4; i++) begin
                x1_q[i] <= '0;
                x2_q[i] <= '0;
            end
            d_q       <= '0;
            w0_q      <= '0;
            w1_q      <= '0;
            w2_q      <= '0;
            err_pos_q <= 1'b0;
            err_neg_q <= 1'b0;
            errcnt_q  <= '0;
            p_q       <= '0;
            epochs_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            conv_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q <= S_LOAD;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        conv_q  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    // snapshot the pattern table; inputs are ignored afterwards
                    for (int i = 0; i < 4; i++) begin
                        x1_q[i] <= in1[i*tam +: tam];
                        x2_q[i] <= in2[i*tam +: tam];
                    end
                    d_q      <= d;
                    w0_q     <= w0_init;
                    w1_q     <= w1_init;
                    w2_q     <= w2_init;
                    epochs_q <= '0;
                    p_q      <= '0;
                    errcnt_q <= '0;
                    state_q  <= S_EVAL;
                end
                S_EVAL: begin
                    err_pos_q <= err_pos_d;
                    err_neg_q <= err_neg_d;
                    state_q   <= S_UPDATE;
                end
                S_UPDATE: begin
                    if (err_pos_q || err_neg_q) begin
                        errcnt_q <= errcnt_q + 3'd1;
                    end
                    w0_q <= w0_d;
                    w1_q <= w1_d;
                    w2_q <= w2_d;
                    if (p_q != 2'd3) begin
                        p_q     <= p_q + 2'd1;
                        state_q <= S_EVAL;
                    end else begin
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    epochs_q <= epochs_q + EW'(1);
                    if (errcnt_q == '0) begin
                        conv_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (epochs_q == LAST_EPOCH) begin
                        conv_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        errcnt_q <= '0;
                        p_q      <= '0;
                        state_q  <= S_EVAL;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign w0        = w0_q;
    assign w1        = w1_q;
    assign w2        = w2_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign converged = conv_q;
    assign epochs    = epochs_q;

endmodule

// File: tb/tb_perceptron_trainer_fixed.sv
// Directed bench for perceptron_trainer_fixed: OR, XOR, saturation, reset
// abort, start/input changes during busy, restart from DONE, and AND.
module tb_perceptron_trainer_fixed;

    localparam int unsigned TAM = 16;
    localparam int LIMIT = 2000;

    logic             clk;
    logic             rst;
    logic             start;
    logic [4*TAM-1:0] in1, in2;
    logic [3:0]       d;
    logic [TAM-1:0]   w0_init, w1_init, w2_init;
    logic [TAM-1:0]   w0, w1, w2;
    logic             busy, done, converged;
    logic [6:0]       epochs;

    int tests;
    int fails;
    int n;

    // x1 = 0,1,0,1 and x2 = 0,0,1,1 (1.0 = 0x0100), pattern 0 in low word
    localparam logic [4*TAM-1:0] X1_STD = {16'h0100, 16'h0000, 16'h0100, 16'h0000};
    localparam logic [4*TAM-1:0] X2_STD = {16'h0100, 16'h0100, 16'h0000, 16'h0000};

    perceptron_trainer_fixed dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in1       (in1),
        .in2       (in2),
        .d         (d),
        .w0_init   (w0_init),
        .w1_init   (w1_init),
        .w2_init   (w2_init),
        .w0        (w0),
        .w1        (w1),
        .w2        (w2),
        .busy      (busy),
        .done      (done),
        .converged (converged),
        .epochs    (epochs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse start (edge 0), then count edges until done rises.
    task automatic run_to_done(output int edges);
        start = 1'b1;
        tick();
        start = 1'b0;
        edges = 0;
        while (!done && edges < LIMIT) begin
            tick();
            edges++;
        end
    endtask

    function automatic logic signed [15:0] m_sat(input longint v);
        if (v > 32767) return 16'sh7FFF;
        if (v < -32768) return 16'sh8000;
        return 16'(v);
    endfunction

    // Reference neuron: y = (sum > 0) with saturating arithmetic.
    function automatic logic m_y(input logic signed [15:0] a0, input logic signed [15:0] a1,
                                 input logic signed [15:0] a2, input logic signed [15:0] x1,
                                 input logic signed [15:0] x2);
        longint p1, p2, s;
        p1 = m_sat((longint'(a1) * longint'(x1)) >>> 8);
        p2 = m_sat((longint'(a2) * longint'(x2)) >>> 8);
        s  = m_sat(m_sat(longint'(a0) + p1) + p2);
        return s > 0;
    endfunction

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        start = 1'b0;
        in1 = X1_STD;
        in2 = X2_STD;
        d = 4'b1110;
        w0_init = '0;
        w1_init = '0;
        w2_init = '0;
        tick();
        tick();
        rst = 1'b0;

        // reset state
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_conv", 32'(converged), 32'h0);
        check("rst_epochs", 32'(epochs), 32'h0);
        check("rst_w", {w0, w1}, 32'h0);

        // OR
        run_to_done(n);
        check("or_edges", 32'(n), 32'd37);
        check("or_conv", 32'(converged), 32'h1);
        check("or_epochs", 32'(epochs), 32'd4);
        check("or_w0", 32'(w0), 32'h0000);
        check("or_w1", 32'(w1), 32'h0040);
        check("or_w2", 32'(w2), 32'h0040);
        check("or_busy", 32'(busy), 32'h0);

        // XOR never converges; weights settle into a one-epoch cycle
        d = 4'b0110;
        run_to_done(n);
        check("xor_edges", 32'(n), 32'd577);
        check("xor_conv", 32'(converged), 32'h0);
        check("xor_epochs", 32'(epochs), 32'd64);
        check("xor_w0", 32'(w0), 32'h0040);
        check("xor_w1", 32'(w1), 32'h0000);
        check("xor_w2", 32'(w2), 32'hFFC0);

        // saturation: all sums clamp to max, single clean epoch
        d = 4'b1111;
        w0_init = 16'h7FFF;
        w1_init = 16'h7FFF;
        w2_init = 16'h7FFF;
        run_to_done(n);
        check("sat_edges", 32'(n), 32'd10);
        check("sat_conv", 32'(converged), 32'h1);
        check("sat_epochs", 32'(epochs), 32'd1);
        check("sat_w", {w0, w1}, 32'h7FFF7FFF);
        check("sat_w2", 32'(w2), 32'h7FFF);

        // reset at edge 15 of an OR run
        d = 4'b1110;
        w0_init = '0;
        w1_init = '0;
        w2_init = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 14; i++) tick();
        check("mid_busy_pre", 32'(busy), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_busy", 32'(busy), 32'h0);
        check("mid_done", 32'(done), 32'h0);
        check("mid_conv", 32'(converged), 32'h0);
        check("mid_epochs", 32'(epochs), 32'h0);
        check("mid_w01", {w0, w1}, 32'h0);
        check("mid_w2", 32'(w2), 32'h0);
        tick();
        check("mid_idle", {31'h0, busy}, 32'h0);
        run_to_done(n);
        check("mid_or_edges", 32'(n), 32'd37);
        check("mid_or_w", {w0, w1}, 32'h00000040);
        check("mid_or_w2", 32'(w2), 32'h0040);
        check("mid_or_epochs", 32'(epochs), 32'd4);

        // start pulse and input changes while busy are ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n++;
        end
        start = 1'b1;
        in1 = {4{16'h7FFF}};
        d = 4'b0000;
        tick();
        n++;
        start = 1'b0;
        while (!done && n < LIMIT) begin
            tick();
            n++;
        end
        check("bsy_edges", 32'(n), 32'd37);
        check("bsy_conv", 32'(converged), 32'h1);
        check("bsy_epochs", 32'(epochs), 32'd4);
        check("bsy_w", {w0, w1}, 32'h00000040);
        check("bsy_w2", 32'(w2), 32'h0040);

        // start in DONE: done drops on the next edge and training restarts
        in1 = X1_STD;
        d = 4'b1110;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rs_done", 32'(done), 32'h0);
        check("rs_busy", 32'(busy), 32'h1);
        check("rs_conv", 32'(converged), 32'h0);
        n = 0;
        while (!done && n < LIMIT) begin
            tick();
            n++;
        end
        check("rs_edges", 32'(n), 32'd37);

        // AND
        d = 4'b1000;
        run_to_done(n);
        check("and_edges", 32'(n), 32'd55);
        check("and_conv", 32'(converged), 32'h1);
        check("and_epochs", 32'(epochs), 32'd6);
        check("and_w0", 32'(w0), 32'hFF80);
        check("and_w1", 32'(w1), 32'h0040);
        check("and_w2", 32'(w2), 32'h0080);
        for (int p = 0; p < 4; p++) begin
            logic [4*TAM-1:0] a1, a2;
            a1 = X1_STD;
            a2 = X2_STD;
            check($sformatf("and_y%0d", p),
                  32'(m_y(w0, w1, w2, a1[p*TAM +: TAM], a2[p*TAM +: TAM])),
                  32'(p == 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
